phv_out_fifo: RTL and testbench

// - Buffers packet header vectors (PHVs) produced by the packet header parser and delivers them to the first match-action stage.
// - The parser's output is a single-cycle parser_valid pulse with no backpressure. This block absorbs those pulses and re-presents each PHV under a valid/ready handshake.
// - Counts PHVs lost to overflow.
// - First-word-fall-through FIFO with an occupancy count, full/empty flags and a saturating drop counter.

---
 rtl/phv_out_fifo_pkg.sv | 19 +
 rtl/phv_fifo_ram.sv | 46 ++++
 rtl/phv_out_fifo.sv | 142 ++++++++++++++
 tb/tb_phv_out_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/phv_out_fifo_pkg.sv
// Shared definitions for the PHV output FIFO.
// Holds the default PHV geometry, the location of the tuser_1st field inside a PHV,
// the default FIFO depth and the control-state encoding used by the top level.
package phv_out_fifo_pkg;

    localparam int DEFAULT_PKT_HDR_LEN = 1124;
    localparam int DEFAULT_DEPTH       = 8;

    // tuser_1st sits in the low bits of every PHV
    localparam int TUSER_OFF = 0;
    localparam int TUSER_W   = 128;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/phv_fifo_ram.sv
// Simple dual-port PHV storage, DEPTH x WIDTH.
// Synchronous write and a registered read, so the array maps onto BRAM/LUTRAM.
// Ports:
//   axis_clk  clock
//   aresetn   synchronous active-low reset (clears only the read register)
//   wr_en     write strobe
//   wr_addr   write address
//   wr_data   write data
//   rd_addr   read address, sampled every cycle
//   rd_data   registered read data
module phv_fifo_ram #(
    parameter int WIDTH  = 1124,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              axis_clk,
    input  logic              aresetn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge axis_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Write-first on an address collision: when an entry is written into the slot
    // that becomes the head in the same cycle, the new data must reach rd_data
    // after this edge rather than the stale array contents.
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            rd_data <= '0;
        end else if (wr_en && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/phv_out_fifo.sv
// First-word-fall-through FIFO between the packet header parser and the first
// match-action stage. Absorbs single-cycle parser strobes (no backpressure) and
// re-presents each PHV under a valid/ready handshake; PHVs arriving while full
// with no pop are dropped and counted by a saturating counter.
// Ports:
//   axis_clk       clock
//   aresetn        synchronous active-low reset
//   parser_valid   one-cycle strobe qualifying pkt_hdr_vec
//   pkt_hdr_vec    PHV from the parser
//   phv_out        registered head-of-FIFO PHV
//   phv_out_valid  phv_out holds a valid entry
//   phv_out_ready  downstream accepts phv_out this cycle
//   fifo_full      occupancy == DEPTH
//   fifo_empty     occupancy == 0
//   occupancy      number of stored entries
//   drop_cnt       PHVs lost to overflow, saturating
module phv_out_fifo
    import phv_out_fifo_pkg::*;
#(
    parameter int PKT_HDR_LEN = DEFAULT_PKT_HDR_LEN,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int ADDR_W      = 3,
    parameter int CNT_W       = 16
) (
    input  logic                   axis_clk,
    input  logic                   aresetn,
    input  logic                   parser_valid,
    input  logic [PKT_HDR_LEN-1:0] pkt_hdr_vec,
    output logic [PKT_HDR_LEN-1:0] phv_out,
    output logic                   phv_out_valid,
    input  logic                   phv_out_ready,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic [ADDR_W:0]        occupancy,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam logic [ADDR_W:0]   OCC_ONE      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   OCC_NEARFULL = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE      = ADDR_W'(1);

    fifo_state_t       state;
    fifo_state_t       state_next;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_ptr_next;
    logic              push;
    logic              pop;
    logic              drop;
    logic              ram_wr_en;

    // Flags are decoded straight from the state register, so they change on the
    // same edge as occupancy and never disagree with it.
    assign fifo_empty    = (state == FIFO_EMPTY);
    assign fifo_full     = (state == FIFO_FULL);
    assign phv_out_valid = (state != FIFO_EMPTY);

    // A full FIFO still accepts a PHV when the head leaves in the same cycle.
    assign pop         = phv_out_valid & phv_out_ready;
    assign push        = parser_valid & (~fifo_full | pop);
    assign drop        = parser_valid & fifo_full & ~pop;
    assign rd_ptr_next = pop ? rd_ptr + PTR_ONE : rd_ptr;
    assign ram_wr_en   = push & aresetn;

    always_comb begin
        state_next = state;
        case (state)
            FIFO_EMPTY: begin
                if (push) begin
                    state_next = FIFO_PARTIAL;
                end
            end
            FIFO_PARTIAL: begin
                if (push && !pop && (occupancy == OCC_NEARFULL)) begin
                    state_next = FIFO_FULL;
                end else if (pop && !push && (occupancy == OCC_ONE)) begin
                    state_next = FIFO_EMPTY;
                end
            end
            FIFO_FULL: begin
                if (pop && !push) begin
                    state_next = FIFO_PARTIAL;
                end
            end
            default: begin
                state_next = FIFO_EMPTY;
            end
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state <= FIFO_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr <= rd_ptr_next;
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    // The read address is the post-update head, so phv_out lands one edge after
    // the push or pop that defines it.
    phv_fifo_ram #(
        .WIDTH  (PKT_HDR_LEN),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .axis_clk (axis_clk),
        .aresetn  (aresetn),
        .wr_en    (ram_wr_en),
        .wr_addr  (wr_ptr),
        .wr_data  (pkt_hdr_vec),
        .rd_addr  (rd_ptr_next),
        .rd_data  (phv_out)
    );

endmodule

// File: tb/tb_phv_out_fifo.sv
// Randomized self-checking bench for phv_out_fifo. A queue-based reference model
// tracks the stored PHVs and the drop counts; two DUT instances share the stimulus,
// one with a 16-bit drop counter and one with a 2-bit counter to exercise saturation.
module tb_phv_out_fifo;
    import phv_out_fifo_pkg::*;

    localparam int W      = DEFAULT_PKT_HDR_LEN;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 16;
    localparam int CHUNK  = 256;
    localparam int NCHUNK = (W + CHUNK - 1) / CHUNK;

    logic              axis_clk;
    logic              aresetn;
    logic              parser_valid;
    logic [W-1:0]      pkt_hdr_vec;
    logic              phv_out_ready;

    logic [W-1:0]      phv_out;
    logic              phv_out_valid;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W:0]   occupancy;
    logic [CNT_W-1:0]  drop_cnt;

    logic [W-1:0]      sat_phv_out;
    logic              sat_phv_out_valid;
    logic              sat_fifo_full;
    logic              sat_fifo_empty;
    logic [ADDR_W:0]   sat_occupancy;
    logic [1:0]        sat_drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] model_q[$];
    int           model_drop;
    int           model_drop_sat;
    bit           model_after_reset;

    phv_out_fifo #(
        .PKT_HDR_LEN (W), .DEPTH (DEPTH), .ADDR_W (ADDR_W), .CNT_W (CNT_W)
    ) dut (
        .axis_clk      (axis_clk),
        .aresetn       (aresetn),
        .parser_valid  (parser_valid),
        .pkt_hdr_vec   (pkt_hdr_vec),
        .phv_out       (phv_out),
        .phv_out_valid (phv_out_valid),
        .phv_out_ready (phv_out_ready),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .occupancy     (occupancy),
        .drop_cnt      (drop_cnt)
    );

    phv_out_fifo #(
        .PKT_HDR_LEN (W), .DEPTH (DEPTH), .ADDR_W (ADDR_W), .CNT_W (2)
    ) dut_sat (
        .axis_clk      (axis_clk),
        .aresetn       (aresetn),
        .parser_valid  (parser_valid),
        .pkt_hdr_vec   (pkt_hdr_vec),
        .phv_out       (sat_phv_out),
        .phv_out_valid (sat_phv_out_valid),
        .phv_out_ready (phv_out_ready),
        .fifo_full     (sat_fifo_full),
        .fifo_empty    (sat_fifo_empty),
        .occupancy     (sat_occupancy),
        .drop_cnt      (sat_drop_cnt)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    task automatic checkOutput(input string tag, input logic [CHUNK-1:0] observed,
                               input logic [CHUNK-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [NCHUNK*CHUNK-1:0] t;
        for (int i = 0; i < NCHUNK * CHUNK / 32; i++) begin
            t[i*32 +: 32] = $urandom;
        end
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] mk_vec(input logic [TUSER_W-1:0] tu);
        logic [W-1:0] v;
        v = rand_vec();
        v[TUSER_OFF +: TUSER_W] = tu;
        return v;
    endfunction

    // Compares every observable output against the reference model.
    task automatic verifyState();
        logic [NCHUNK*CHUNK-1:0] obs_pad;
        logic [NCHUNK*CHUNK-1:0] exp_pad;
        logic [W-1:0]            head;
        checkOutput("phv_out_valid", CHUNK'(phv_out_valid), CHUNK'(model_q.size() != 0));
        checkOutput("fifo_empty", CHUNK'(fifo_empty), CHUNK'(model_q.size() == 0));
        checkOutput("fifo_full", CHUNK'(fifo_full), CHUNK'(model_q.size() == DEPTH));
        checkOutput("occupancy", CHUNK'(occupancy), CHUNK'(model_q.size()));
        checkOutput("drop_cnt", CHUNK'(drop_cnt), CHUNK'(model_drop));
        checkOutput("drop_cnt_sat", CHUNK'(sat_drop_cnt), CHUNK'(model_drop_sat));
        if (model_q.size() != 0 || model_after_reset) begin
            head = (model_q.size() != 0) ? model_q[0] : '0;
            obs_pad = '0;
            exp_pad = '0;
            obs_pad[W-1:0] = phv_out;
            exp_pad[W-1:0] = head;
            for (int k = 0; k < NCHUNK; k++) begin
                checkOutput($sformatf("phv_out[%0d]", k), obs_pad[k*CHUNK +: CHUNK],
                            exp_pad[k*CHUNK +: CHUNK]);
            end
        end
    endtask

    // Drives one cycle of inputs, advances the model across the edge, then checks.
    task automatic applyStimulus(input logic rstn, input logic pv, input logic rdy,
                                 input logic [W-1:0] vec);
        bit was_full;
        bit do_pop;
        aresetn       = rstn;
        parser_valid  = pv;
        phv_out_ready = rdy;
        pkt_hdr_vec   = vec;
        @(posedge axis_clk);
        if (!rstn) begin
            model_q.delete();
            model_drop        = 0;
            model_drop_sat    = 0;
            model_after_reset = 1'b1;
        end else begin
            model_after_reset = 1'b0;
            was_full = (model_q.size() == DEPTH);
            do_pop   = (model_q.size() != 0) && rdy;
            if (do_pop) void'(model_q.pop_front());
            if (pv) begin
                if (!was_full || do_pop) begin
                    model_q.push_back(vec);
                end else begin
                    if (model_drop < 65535) model_drop++;
                    if (model_drop_sat < 3) model_drop_sat++;
                end
            end
        end
        #1;
        verifyState();
    endtask

    initial begin
        aresetn           = 1'b0;
        parser_valid      = 1'b0;
        phv_out_ready     = 1'b0;
        pkt_hdr_vec       = '0;
        model_drop        = 0;
        model_drop_sat    = 0;
        model_after_reset = 1'b1;

        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, rand_vec());

        $display("[TB] single PHV");
        applyStimulus(1'b1, 1'b1, 1'b1, mk_vec(128'hA5));
        applyStimulus(1'b1, 1'b0, 1'b1, rand_vec());
        applyStimulus(1'b1, 1'b0, 1'b1, rand_vec());

        $display("[TB] fill and overflow");
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, mk_vec(TUSER_W'(i)));
        applyStimulus(1'b1, 1'b1, 1'b0, mk_vec(128'd99));

        $display("[TB] push and pop while full");
        applyStimulus(1'b1, 1'b1, 1'b1, mk_vec(128'd9));
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'b1, rand_vec());

        $display("[TB] hold stability");
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'($urandom_range(1, 0)), rand_vec());
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, 1'($urandom_range(1, 0)), rand_vec());
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'b1, rand_vec());

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, mk_vec(TUSER_W'(i + 20)));
        applyStimulus(1'b1, 1'b1, 1'b0, rand_vec());
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, rand_vec());
        applyStimulus(1'b1, 1'b1, 1'b0, mk_vec(128'd50));
        applyStimulus(1'b0, 1'b1, 1'b0, mk_vec(128'd77));
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, rand_vec());

        $display("[TB] counter saturation");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, rand_vec());
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, rand_vec());
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'b1, rand_vec());

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(99, 0) != 0), 1'($urandom_range(2, 0) != 0),
                          1'($urandom_range(1, 0)), rand_vec());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
